// File: rtl/muldiv_if.sv
// Handshake bundle between the control unit and muldiv_unit.
// master drives start/op/operands/mthi/mtlo/wr_data; slave returns busy/done/hi/lo.
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    output mthi, mtlo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    input  mthi, mtlo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Ports: clk, rst (sync, active-high), bus (muldiv_if.slave). Option: MULDIV_FAST_MUL_EN.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic              sgn_a;
  logic              sgn_b;
  logic              b_zero;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] rs_raw;
  logic [W2-1:0]     acc;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              busy_q;
  logic              done_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes for the incoming op.
  logic              in_signed;
  logic [DATA_W-1:0] abs_rs;
  logic [DATA_W-1:0] abs_rt;

  assign in_signed = ~bus.op[0];
  assign abs_rs = (in_signed && bus.rs_data[DATA_W-1])
                ? -bus.rs_data : bus.rs_data;
  assign abs_rt = (in_signed && bus.rt_data[DATA_W-1])
                ? -bus.rt_data : bus.rt_data;

  // Multiply step: acc = {partial, multiplier}, add on LSB then shift.
  logic [DATA_W:0] msum;
  logic [W2-1:0]   mul_next;

  assign msum = {1'b0, acc[W2-1:DATA_W]}
              + (acc[0] ? {1'b0, m} : '0);
  assign mul_next = {msum, acc[DATA_W-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}.
  logic [DATA_W:0] shl;
  logic [DATA_W:0] diff;
  logic [W2-1:0]   div_next;

  assign shl  = acc[W2-1:DATA_W-1];
  assign diff = shl - {1'b0, m};
  assign div_next = diff[DATA_W]
    ? {shl[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
    : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

  // Sign correction and result selection for FIX.
  logic              q_signed;
  logic [W2-1:0]     prod;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  assign q_signed = ~op_q[0];
  assign prod = (q_signed && (sgn_a ^ sgn_b)) ? -acc : acc;
  assign quo  = acc[DATA_W-1:0];
  assign rem  = acc[W2-1:DATA_W];

  always_comb begin
    res_hi = prod[W2-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (op_q[1]) begin
      if (b_zero) begin
        res_hi = rs_raw;
        res_lo = '1;
      end else begin
        res_lo = (q_signed && (sgn_a ^ sgn_b)) ? -quo : quo;
        res_hi = (q_signed && sgn_a) ? -rem : rem;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Extending to 2*DATA_W makes one unsigned multiply serve both signednesses.
  logic [W2-1:0] ext_a;
  logic [W2-1:0] ext_b;
  logic [W2-1:0] fast_prod;

  assign ext_a = in_signed
    ? {{DATA_W{bus.rs_data[DATA_W-1]}}, bus.rs_data}
    : {{DATA_W{1'b0}}, bus.rs_data};
  assign ext_b = in_signed
    ? {{DATA_W{bus.rt_data[DATA_W-1]}}, bus.rt_data}
    : {{DATA_W{1'b0}}, bus.rt_data};
  assign fast_prod = ext_a * ext_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      b_zero <= 1'b0;
      m      <= '0;
      rs_raw <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              hi_q   <= fast_prod[W2-1:DATA_W];
              lo_q   <= fast_prod[DATA_W-1:0];
              done_q <= 1'b1;
            end else begin
`else
            begin
`endif
              state  <= RUN;
              busy_q <= 1'b1;
              cnt    <= '0;
              op_q   <= bus.op;
              sgn_a  <= in_signed & bus.rs_data[DATA_W-1];
              sgn_b  <= in_signed & bus.rt_data[DATA_W-1];
              b_zero <= (bus.rt_data == '0);
              rs_raw <= bus.rs_data;
              if (bus.op[1]) begin
                m   <= abs_rt;
                acc <= {{DATA_W{1'b0}}, abs_rs};
              end else begin
                m   <= abs_rs;
                acc <= {{DATA_W{1'b0}}, abs_rt};
              end
            end
          end else begin
            if (bus.mthi) hi_q <= bus.wr_data;
            if (bus.mtlo) lo_q <= bus.wr_data;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= FIX;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
